// File: rtl/subtractor_core_if.sv
// subtractor_core_if
//   Operand/result bundle for subtractor_core. Clock and reset remain
//   scalar ports on the core. Signal names match the original flat ports.
//   master: drives in_valid, A, B; observes out_valid, Y, N, Z, C, V
//   slave : the subtractor core itself
interface subtractor_core_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] Y;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;

  modport master (
    output in_valid, A, B,
    input  out_valid, Y, N, Z, C, V
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, Y, N, Z, C, V
  );
endinterface

// File: rtl/subtractor_core.sv
// subtractor_core
//   Registered two's-complement subtractor Y = A - B with NZCV flags.
//   One-cycle latency, accepts one operand pair per cycle, no stall.
//   When in_valid is low, Y and flags hold; out_valid drops.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every output flop
//   bus    : subtractor_core_if.slave (in_valid, A, B -> out_valid, Y, N, Z, C, V)
// Build option
//   SUBTRACTOR_SAT_EN : when defined, Y clamps to the signed limit on
//                       overflow; V and C still report the raw result.
module subtractor_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  subtractor_core_if.slave   bus
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_y;
  logic             w_c;
  logic             w_v;

  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_n;
  logic             r_z;
  logic             r_c;
  logic             r_v;

  // A + ~B + 1 in WIDTH+1 bits: the carry out is the "no borrow" flag.
  always_comb begin
    w_sum = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
    w_raw = w_sum[WIDTH-1:0];
    w_c   = w_sum[WIDTH];
    w_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_raw[WIDTH-1] != bus.A[WIDTH-1]);
`ifdef SUBTRACTOR_SAT_EN
    // On overflow the true result lies beyond the limit on A's side.
    if (w_v) begin
      w_y = bus.A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_y = w_raw;
    end
`else
    w_y   = w_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_y <= w_y;
        r_n <= w_y[WIDTH-1];
        r_z <= (w_y == '0);
        r_c <= w_c;
        r_v <= w_v;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.Y         = r_y;
  assign bus.N         = r_n;
  assign bus.Z         = r_z;
  assign bus.C         = r_c;
  assign bus.V         = r_v;

endmodule

// File: tb/tb_subtractor_core.sv
module tb_subtractor_core;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] y;
    logic         n, z, c, v;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  subtractor_core_if #(.WIDTH(W)) bus ();

  subtractor_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  exp_t last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W+4:0] act, input logic [W+4:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: subtraction on wide signed/unsigned integers, then range checks.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_, d;
    bit     ovf;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    d   = sa - sb_;
    ovf = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    e.y = a - b;
`ifdef SUBTRACTOR_SAT_EN
    if (ovf) e.y = (d < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.n   = e.y[W-1];
    e.z   = (e.y == 0);
    e.c   = (a >= b);
    e.v   = ovf;
    e.due = 0;
    return e;
  endfunction

  function automatic logic [W+4:0] pack(input logic vld, input exp_t e);
    return {vld, e.y, e.n, e.z, e.c, e.v};
  endfunction

  function automatic logic [W+4:0] dut_out();
    return {bus.out_valid, bus.Y, bus.N, bus.Z, bus.C, bus.V};
  endfunction

  // Monitor: every falling edge, either a result is due or outputs must hold.
  initial begin
    exp_t e;
    last = '{y: '0, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, due: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = '{y: '0, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0, due: 0};
        chk("reset_hold", dut_out(), '0);
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("result", dut_out(), pack(1'b1, e));
        last = e;
      end else begin
        chk("idle_hold", dut_out(), pack(1'b0, last));
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    e = model(a, b);
    e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [5];
    edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    case ($urandom_range(3))
      0:       return edges[$urandom_range(4)];
      1:       return W'($urandom_range(255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] a, b;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;

    #1 rst_n = 1'b0;
    #1 chk("reset_async_init", dut_out(), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    drive(32'd1, 32'd1);
    drive(32'd2412, 32'd321);
    drive(32'd321, 32'd2412);
    drive(32'd415151, 32'd164);
    idle(); idle();

    for (int unsigned k = 0; k < 4; k++) drive(32'd0, k);
    idle(); idle(); idle();

    drive(32'h8000_0000, 32'd1);
    drive(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle();

    for (int i = 0; i < 200; i++) begin
      a = pick();
      b = ($urandom_range(7) == 0) ? a : pick();
      if ($urandom_range(3) == 0) idle();
      else drive(a, b);
    end

    // Mid-stream reset: the pair presented just before reset must vanish.
    drive(32'd100, 32'd7);
    drive(32'd55, 32'd99);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 chk("reset_async_mid", dut_out(), '0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(); idle();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(4) == 0) idle();
      else drive(pick(), pick());
    end
    idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", W'(sb.size()), '0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
